sequenciador_programa: RTL and testbench

Program sequencer that drives the multicycle processor from a small synchronous instruction memory. It fetches 16-bit words, presents each instruction on the processor's `DIN`, and pulses `Run`. For `mvi` it supplies the immediate word in the following cycle. It then waits for `Done` before fetching the next instruction. It sits between the instruction ROM and `processador_multiciclo`, and replaces manual switch/button stimulus.

---
 rtl/seq_pkg.sv | 32 +++
 rtl/contador_programa.sv | 42 ++++
 rtl/sequenciador_programa.sv | 180 ++++++++++++++++++
 tb/tb_sequenciador_programa.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the program sequencer.
//   - INSTR_W: instruction/data word width.
//   - OP_*: opcode field values (instruction bits [8:6]).
//   - estado_t: sequencer FSM state encoding, also exported for debug.
//   - opcode_of(): extracts the opcode field from a word.
package seq_pkg;

    localparam int INSTR_W = 16;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        BUSCA     = 4'd1,
        CAPTURA   = 4'd2,
        BUSCA_IMM = 4'd3,
        EMITE     = 4'd4,
        IMEDIATO  = 4'd5,
        AGUARDA   = 4'd6,
        PAUSA     = 4'd7,
        PARADO    = 4'd8
    } estado_t;

    function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[8:6];
    endfunction

endpackage

// File: rtl/contador_programa.sv
// contador_programa: program counter register.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset (PC -> 0)
//   clr_i  : synchronous clear (PC -> 0), wins over increment
//   inc_i  : advance PC this cycle
//   inc2_i : when advancing, step by 2 (instruction + immediate) instead of 1
//   pc_o   : current PC; arithmetic wraps modulo 2^ADDR_W
module contador_programa #(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic              inc2_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (inc_i) begin
            // Truncating add gives the modulo-2^ADDR_W wrap for free.
            pc_d = pc_q + (inc2_i ? ADDR_W'(2) : ADDR_W'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/sequenciador_programa.sv
// sequenciador_programa: fetches instructions from a synchronous ROM and
// feeds them to the multicycle processor.
//   Clock, Reset      : rising-edge clock, synchronous active-high reset
//   Start             : pulse, (re)starts execution at address 0 (idle/halted only)
//   Step_mode, Step   : pause after each retired instruction / resume pulse
//   Mem_rd, Mem_addr  : ROM read strobe and address
//   Mem_data          : ROM data, valid the cycle after Mem_rd
//   DIN, Run, Done    : processor data input, start pulse, completion
//   Busy, Halted, Erro: running / stopped / sticky Done-timeout flag
//   PC, Instr_count   : current instruction address, retired instructions
//   Estado_o          : current FSM state (debug)
//
// Processor handshake: Run is high for exactly one cycle (EMITE) with the
// instruction on DIN; for mvi the immediate is on DIN the following cycle.
// Done is sampled from the cycle after Run onwards and retires the
// instruction in the cycle it is seen high; a Done in the Run cycle is ignored.
module sequenciador_programa
    import seq_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Step_mode,
    input  logic               Step,
    output logic               Mem_rd,
    output logic [ADDR_W-1:0]  Mem_addr,
    input  logic [INSTR_W-1:0] Mem_data,
    output logic [INSTR_W-1:0] DIN,
    output logic               Run,
    input  logic               Done,
    output logic               Busy,
    output logic               Halted,
    output logic               Erro,
    output logic [ADDR_W-1:0]  PC,
    output logic [15:0]        Instr_count,
    output estado_t            Estado_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    estado_t              estado_q, estado_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [INSTR_W-1:0]   imm_q, imm_d;
    logic [INSTR_W-1:0]   din_q;
    logic [INSTR_W-1:0]   din_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 erro_q, erro_d;
    logic                 pc_clr, pc_inc, pc_inc2;
    logic                 run_emit;
    logic                 ir_is_mvi;

    contador_programa #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .clr_i  (pc_clr),
        .inc_i  (pc_inc),
        .inc2_i (pc_inc2),
        .pc_o   (PC)
    );

    assign ir_is_mvi = (opcode_of(ir_q) == OP_MVI);

    always_comb begin
        estado_d = estado_q;
        ir_d     = ir_q;
        imm_d    = imm_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        erro_d   = erro_q;
        din_d    = din_q;      // DIN holds its last value unless driven below
        pc_clr   = 1'b0;
        pc_inc   = 1'b0;
        pc_inc2  = 1'b0;
        Mem_rd   = 1'b0;
        Mem_addr = PC;
        run_emit = 1'b0;

        case (estado_q)
            OCIOSO, PARADO: begin
                if (Start) begin
                    pc_clr   = 1'b1;
                    cnt_d    = '0;
                    erro_d   = 1'b0;
                    estado_d = BUSCA;
                end
            end
            BUSCA: begin
                Mem_rd   = 1'b1;
                estado_d = CAPTURA;
            end
            CAPTURA: begin
                ir_d = Mem_data;
                if (opcode_of(Mem_data) == OP_HALT) begin
                    estado_d = PARADO;
                end else if (opcode_of(Mem_data) == OP_MVI) begin
                    // Immediate read overlaps the capture cycle.
                    Mem_rd   = 1'b1;
                    Mem_addr = PC + ADDR_W'(1);
                    estado_d = BUSCA_IMM;
                end else begin
                    estado_d = EMITE;
                end
            end
            BUSCA_IMM: begin
                imm_d    = Mem_data;
                estado_d = EMITE;
            end
            EMITE: begin
                run_emit = 1'b1;
                din_d    = ir_q;
                wait_d   = '0;
                estado_d = ir_is_mvi ? IMEDIATO : AGUARDA;
            end
            IMEDIATO, AGUARDA: begin
                if (estado_q == IMEDIATO) begin
                    din_d = imm_q;
                end
                if (Done) begin
                    cnt_d    = cnt_q + 16'd1;
                    pc_inc   = 1'b1;
                    pc_inc2  = ir_is_mvi;
                    estado_d = Step_mode ? PAUSA : BUSCA;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    // TIMEOUT wait cycles elapsed without Done.
                    erro_d   = 1'b1;
                    estado_d = PARADO;
                end else begin
                    wait_d   = wait_q + WAIT_W'(1);
                    estado_d = AGUARDA;
                end
            end
            PAUSA: begin
                if (Step) begin
                    estado_d = BUSCA;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado_q <= OCIOSO;
            ir_q     <= '0;
            imm_q    <= '0;
            din_q    <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            ir_q     <= ir_d;
            imm_q    <= imm_d;
            din_q    <= din_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            erro_q   <= erro_d;
        end
    end

    // DIN follows the value being driven this cycle so the instruction and the
    // immediate appear in the Run cycle and the one after, respectively.
    assign DIN         = din_d;
    // Reset removes Run combinationally so an in-flight pulse is cut short.
    assign Run         = run_emit & ~Reset;
    assign Busy        = (estado_q != OCIOSO) && (estado_q != PARADO);
    assign Halted      = (estado_q == PARADO);
    assign Erro        = erro_q;
    assign Instr_count = cnt_q;
    assign Estado_o    = estado_q;

endmodule

// File: tb/tb_sequenciador_programa.sv
module tb_sequenciador_programa;
    import seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, step_mode, step, start3;

    // ---------------- DUT (ADDR_W = 5) ----------------
    logic        mem_rd, run, done, busy, halted, erro;
    logic [4:0]  mem_addr, pc;
    logic [15:0] mem_data, din, icount;
    estado_t     estado;

    sequenciador_programa #(.ADDR_W(5), .TIMEOUT(15)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .Step_mode(step_mode), .Step(step),
        .Mem_rd(mem_rd), .Mem_addr(mem_addr), .Mem_data(mem_data),
        .DIN(din), .Run(run), .Done(done), .Busy(busy), .Halted(halted), .Erro(erro),
        .PC(pc), .Instr_count(icount), .Estado_o(estado)
    );

    // ---------------- DUT (ADDR_W = 3) for wrap-around ----------------
    logic        mem_rd3, run3, done3, busy3, halted3, erro3;
    logic [2:0]  mem_addr3, pc3;
    logic [15:0] mem_data3, din3, icount3;
    estado_t     estado3;

    sequenciador_programa #(.ADDR_W(3), .TIMEOUT(15)) dut3 (
        .Clock(clk), .Reset(rst), .Start(start3), .Step_mode(1'b0), .Step(1'b0),
        .Mem_rd(mem_rd3), .Mem_addr(mem_addr3), .Mem_data(mem_data3),
        .DIN(din3), .Run(run3), .Done(done3), .Busy(busy3), .Halted(halted3), .Erro(erro3),
        .PC(pc3), .Instr_count(icount3), .Estado_o(estado3)
    );

    // ---------------- memories ----------------
    logic [15:0] mem [32];
    logic [15:0] mem3 [8];
    always @(posedge clk) if (mem_rd)  mem_data  <= mem[mem_addr];
    always @(posedge clk) if (mem_rd3) mem_data3 <= mem3[mem_addr3];

    // second DUT's processor: every instruction finishes in T1
    always @(posedge clk) done3 <= rst ? 1'b0 : run3;

    // ---------------- processor model ----------------
    // mv/mvi finish in T1, add/sub in T3 (T0 = Run cycle).
    logic        model_en, done_en, done_drv, m_done;
    logic [15:0] rf [8];
    logic [15:0] m_ir;
    logic [2:0]  m_t;
    int          run_cnt;

    always_comb begin
        m_done = 1'b0;
        if (m_t != 3'd0 && done_en)
            m_done = (m_ir[8:6] == OP_ADD || m_ir[8:6] == OP_SUB) ? (m_t == 3'd3) : (m_t == 3'd1);
    end
    assign done = model_en ? m_done : done_drv;

    always @(posedge clk) begin
        if (rst) begin
            m_t <= 3'd0;
            m_ir <= 16'h0;
            run_cnt <= 0;
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0;
        end else begin
            if (run) run_cnt <= run_cnt + 1;
            if (run) begin
                m_ir <= din;
                m_t  <= 3'd1;
            end else if (m_t != 3'd0) begin
                if (m_done) begin
                    m_t <= 3'd0;
                    case (m_ir[8:6])
                        OP_MV:  rf[m_ir[5:3]] <= rf[m_ir[2:0]];
                        OP_MVI: rf[m_ir[5:3]] <= din;
                        OP_ADD: rf[m_ir[5:3]] <= rf[m_ir[5:3]] + rf[m_ir[2:0]];
                        OP_SUB: rf[m_ir[5:3]] <= rf[m_ir[5:3]] - rf[m_ir[2:0]];
                        default: ;
                    endcase
                end else if (m_t != 3'd7) begin
                    m_t <= m_t + 3'd1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; step = 1'b0; step_mode = 1'b0; start3 = 1'b0;
        done_drv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 16'h01C0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_for(input estado_t s, input int budget, input string name);
        int k;
        k = 0;
        while (estado != s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_reached"}, 64'(estado), 64'(s));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        start;
        logic        done;
        estado_t     st;
        logic        run;
        logic        rd;
        logic [4:0]  addr;
        logic [15:0] din;
        logic [4:0]  pc;
        logic [15:0] cnt;
        logic        busy;
        logic        halted;
    } vec_t;

    vec_t vt [15];

    logic early, rd_seen;

    initial begin : stimulus
        // Basic program, cycle by cycle, Done driven from the table.
        vt[0]  = '{1'b1, 1'b0, OCIOSO,    1'b0, 1'b0, 5'd0, 16'h0000, 5'd0, 16'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, BUSCA,     1'b0, 1'b1, 5'd0, 16'h0000, 5'd0, 16'd0, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b0, CAPTURA,   1'b0, 1'b1, 5'd1, 16'h0000, 5'd0, 16'd0, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b0, BUSCA_IMM, 1'b0, 1'b0, 5'd0, 16'h0000, 5'd0, 16'd0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, EMITE,     1'b1, 1'b0, 5'd0, 16'h0040, 5'd0, 16'd0, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, IMEDIATO,  1'b0, 1'b0, 5'd0, 16'h0005, 5'd0, 16'd0, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b0, BUSCA,     1'b0, 1'b1, 5'd2, 16'h0005, 5'd2, 16'd1, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, CAPTURA,   1'b0, 1'b0, 5'd2, 16'h0005, 5'd2, 16'd1, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b0, EMITE,     1'b1, 1'b0, 5'd2, 16'h0008, 5'd2, 16'd1, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b0, AGUARDA,   1'b0, 1'b0, 5'd2, 16'h0008, 5'd2, 16'd1, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b1, AGUARDA,   1'b0, 1'b0, 5'd2, 16'h0008, 5'd2, 16'd1, 1'b1, 1'b0};
        vt[11] = '{1'b1, 1'b0, BUSCA,     1'b0, 1'b1, 5'd3, 16'h0008, 5'd3, 16'd2, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b0, CAPTURA,   1'b0, 1'b0, 5'd3, 16'h0008, 5'd3, 16'd2, 1'b1, 1'b0};
        vt[13] = '{1'b0, 1'b0, PARADO,    1'b0, 1'b0, 5'd3, 16'h0008, 5'd3, 16'd2, 1'b0, 1'b1};
        vt[14] = '{1'b0, 1'b0, PARADO,    1'b0, 1'b0, 5'd3, 16'h0008, 5'd3, 16'd2, 1'b0, 1'b1};

        model_en = 1'b0;
        done_en  = 1'b1;
        clear_mem();
        mem[0] = 16'h0040; mem[1] = 16'h0005; mem[2] = 16'h0008; mem[3] = 16'h01C0;
        do_reset();
        check("reset_erro", 64'(erro), 64'd0);
        for (int i = 0; i < 15; i++) begin
            start = vt[i].start;
            done_drv = vt[i].done;
            #1;
            check($sformatf("vec%0d", i),
                  {estado, run, mem_rd, mem_addr, din, pc, icount, busy, halted},
                  {vt[i].st, vt[i].run, vt[i].rd, vt[i].addr, vt[i].din, vt[i].pc,
                   vt[i].cnt, vt[i].busy, vt[i].halted});
            @(negedge clk);
        end
        start = 1'b0; done_drv = 1'b0;
        check("vec_erro", 64'(erro), 64'd0);

        // Same program against the processor model.
        model_en = 1'b1;
        do_reset();
        pulse_start();
        wait_for(PARADO, 100, "basic");
        check("basic_r1", 64'(rf[1]), 64'd5);
        check("basic_cnt", 64'(icount), 64'd2);
        check("basic_pc", 64'(pc), 64'd3);
        check("basic_runs", 64'(run_cnt), 64'd2);
        check("basic_flags", {62'd0, halted, erro}, 64'b10);

        // Add/sub.
        clear_mem();
        mem[0] = 16'h0040; mem[1] = 16'h0007; mem[2] = 16'h0048; mem[3] = 16'h0003;
        mem[4] = 16'h0081; mem[5] = 16'h00C1; mem[6] = 16'h01C0;
        do_reset();
        pulse_start();
        wait_for(PARADO, 200, "addsub");
        check("addsub_r0", 64'(rf[0]), 64'd7);
        check("addsub_r1", 64'(rf[1]), 64'd3);
        check("addsub_cnt", 64'(icount), 64'd4);
        check("addsub_pc", 64'(pc), 64'd6);
        check("addsub_runs", 64'(run_cnt), 64'd4);

        // Step mode, with a Start pulse while paused.
        clear_mem();
        mem[0] = 16'h0040; mem[1] = 16'h0009; mem[2] = 16'h0008; mem[3] = 16'h01C0;
        do_reset();
        step_mode = 1'b1;
        pulse_start();
        wait_for(PAUSA, 50, "step1");
        check("step1_cnt", 64'(icount), 64'd1);
        rd_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            #1;
            rd_seen = rd_seen | mem_rd;
            @(negedge clk);
        end
        start = 1'b0;
        check("pause_no_rd", 64'(rd_seen), 64'd0);
        check("pause_state", 64'(estado), 64'(PAUSA));
        check("pause_pc", 64'(pc), 64'd2);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("step_resume", {56'd0, estado, mem_rd, mem_addr}, {56'd0, BUSCA, 1'b1, 5'd2});
        wait_for(PAUSA, 50, "step2");
        check("step2_cnt", 64'(icount), 64'd2);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_for(PARADO, 50, "step_end");
        check("step_r1", 64'(rf[1]), 64'd9);
        step_mode = 1'b0;

        // Timeout: Done never comes.
        clear_mem();
        mem[0] = 16'h0081;
        do_reset();
        done_en = 1'b0;
        pulse_start();
        wait_for(EMITE, 20, "to_emite");
        early = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            early = early | halted | erro;
        end
        check("to_not_early", 64'(early), 64'd0);
        @(negedge clk);
        check("to_flags", {59'd0, erro, halted, busy, 2'b00}, {59'd0, 1'b1, 1'b1, 1'b0, 2'b00});
        check("to_state", 64'(estado), 64'(PARADO));
        check("to_cnt", 64'(icount), 64'd0);
        done_en = 1'b1;
        pulse_start();
        check("restart", {48'd0, erro, estado, mem_rd, mem_addr, pc}, {48'd0, 1'b0, BUSCA, 1'b1, 5'd0, 5'd0});
        wait_for(PARADO, 50, "restart_end");
        check("restart_cnt", 64'(icount), 64'd1);

        // Wrap-around on the 3-bit DUT.
        mem3[0] = 16'hAE08;
        for (int i = 1; i < 7; i++) mem3[i] = 16'h0000;
        mem3[7] = 16'h0040;
        do_reset();
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        begin
            int k;
            k = 0;
            while (!(estado3 == EMITE && pc3 == 3'd7) && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("wrap_emite", {60'd0, run3, pc3}, {60'd0, 1'b1, 3'd7});
            check("wrap_instr", 64'(din3), 64'h0040);
            @(negedge clk);
            check("wrap_imm", 64'(din3), 64'hAE08);
            k = 0;
            while (estado3 != BUSCA && k < 10) begin
                @(negedge clk);
                k++;
            end
            check("wrap_pc", {56'd0, estado3, pc3, mem_rd3}, {56'd0, BUSCA, 3'd1, 1'b1});
            check("wrap_cnt", 64'(icount3), 64'd8);
        end

        // Reset in the Run cycle, then one cycle after Run.
        clear_mem();
        mem[0] = 16'h0081;
        do_reset();
        pulse_start();
        wait_for(EMITE, 20, "rst1");
        rst = 1'b1;
        #1;
        check("rst_run_drop", 64'(run), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst1_state", 64'(estado), 64'(OCIOSO));
        pulse_start();
        wait_for(EMITE, 20, "rst2");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst2_outputs",
              {run, mem_rd, mem_addr, din, busy, halted, erro, pc, icount, estado},
              64'd0);
        @(negedge clk);
        pulse_start();
        check("rst_rerun", {56'd0, estado, mem_rd, mem_addr}, {56'd0, BUSCA, 1'b1, 5'd0});
        wait_for(PARADO, 50, "rerun_end");
        check("rerun_cnt", {32'd0, 16'(run_cnt), icount}, {32'd0, 16'd1, 16'd1});
        check("rerun_pc", 64'(pc), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
